// File: rtl/contador_tics_bcd.sv
// contador_tics_bcd: decimal event counter for single-cycle tic pulses.
// Keeps a DIGITS-wide BCD count with a sticky overflow flag, and drives a
// time-multiplexed 7-segment display that shows one digit at a time.
module contador_tics_bcd #(
    parameter int DIGITS    = 4,
    parameter int SCAN_BITS = 16,
    parameter bit WRAP      = 1'b1,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tic,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Count state
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;

    // Scan state
    logic [SCAN_BITS-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [6:0]           seg_q, seg_d;
    logic [DIGITS-1:0]    an_q, an_d;

    // Combinational helpers
    logic [4*DIGITS-1:0] inc_bcd;
    logic                carry;
    logic                all_nines;
    logic [3:0]          cur_digit;
    logic                cur_blank;
    logic                higher_nz;

    // Segment pattern {g,f,e,d,c,b,a}; codes above 9 never occur.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Full decimal ripple increment in one cycle; carry out of the top digit means all-9s.
    always_comb begin
        // NOTE: every comb output gets a default before any branch, so no latch is inferred.
        inc_bcd = bcd_q;
        carry   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (bcd_q[4*k +: 4] == 4'd9) begin
                    inc_bcd[4*k +: 4] = 4'd0;
                end else begin
                    inc_bcd[4*k +: 4] = bcd_q[4*k +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    // Count next state: clr beats tic; overflow either wraps or saturates, and always sets ovf.
    always_comb begin
        bcd_d = bcd_q;
        ovf_d = ovf_q;
        if (clr) begin
            bcd_d = '0;
            ovf_d = 1'b0;
        end else if (tic) begin
            if (all_nines) begin
                ovf_d = 1'b1;
                bcd_d = WRAP ? {4*DIGITS{1'b0}} : bcd_q;
            end else begin
                bcd_d = inc_bcd;
            end
        end
    end

    // Free-running prescaler; the scan index steps when the prescaler is all-ones.
    always_comb begin
        presc_d = presc_q + SCAN_BITS'(1);
        idx_d   = idx_q;
        if (&presc_q) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Select the indexed digit, decide leading-zero blanking, and build seg/an for the next cycle.
    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        higher_nz = 1'b0;
        an_d      = '1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            higher_nz = higher_nz | (bcd_q[4*k +: 4] != 4'd0);
            if (idx_q == IDX_W'(k)) begin
                cur_digit = bcd_q[4*k +: 4];
                cur_blank = BLANK_LZ && (k != 0) && !higher_nz;
                an_d[k]   = 1'b0;
            end
        end
        seg_d = cur_blank ? 7'h00 : seg_decode(cur_digit);
    end

    // Count registers; reset wins over clr and tic.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            bcd_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            bcd_q <= bcd_d;
            ovf_q <= ovf_d;
        end
    end

    // Display registers; reset lights digit 0 showing "0" so exactly one anode is low from the start.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h3F;
            an_q    <= ~DIGITS'(1);
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bcd = bcd_q;
    assign ovf = ovf_q;
    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_contador_tics_bcd.sv
// Directed bench for contador_tics_bcd: one wrapping and one saturating
// instance, DIGITS=4, SCAN_BITS=2, leading-zero blanking on.
module tb_contador_tics_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tic = 1'b0;
    logic        clr = 1'b0;
    logic        tic_s = 1'b0;
    logic        clr_s = 1'b0;
    logic [15:0] bcd, bcd_s;
    logic        ovf, ovf_s;
    logic [6:0]  seg, seg_s;
    logic [3:0]  an, an_s;

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_edges = 0;   // clock edges since the last reset edge

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    contador_tics_bcd #(.DIGITS(4), .SCAN_BITS(2), .WRAP(1'b1), .BLANK_LZ(1'b1)) dut (
        .clk (clk), .rst (rst), .tic (tic), .clr (clr),
        .bcd (bcd), .ovf (ovf), .seg (seg), .an (an)
    );

    contador_tics_bcd #(.DIGITS(4), .SCAN_BITS(2), .WRAP(1'b0), .BLANK_LZ(1'b1)) dut_sat (
        .clk (clk), .rst (rst), .tic (tic_s), .clr (clr_s),
        .bcd (bcd_s), .ovf (ovf_s), .seg (seg_s), .an (an_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        if (rst) n_edges = 0;
        else     n_edges++;
        #1;
    endtask

    // Back-to-back single-cycle tics on either instance.
    task automatic tics(input int cnt, input bit sat);
        for (int i = 0; i < cnt; i++) begin
            if (sat) tic_s = 1'b1;
            else     tic   = 1'b1;
            step();
        end
        tic   = 1'b0;
        tic_s = 1'b0;
    endtask

    // Advance at least one cycle, then until the anode pattern appears (bounded).
    task automatic wait_an(input logic [3:0] target, input string tag);
        int budget;
        budget = 0;
        do begin
            step();
            budget++;
        end while (an !== target && budget < 40);
        check(tag, {28'd0, an}, {28'd0, target});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        // Reset state
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_bcd", bcd, 0);
        check("rst_ovf", ovf, 0);
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'h3F);
        check("rst_bcd_sat", bcd_s, 0);

        // Basic counting and decimal carry
        tics(12, 1'b0);
        check("bcd_0012", bcd, 16'h0012);
        tics(987, 1'b0);
        check("bcd_0999", bcd, 16'h0999);
        tics(1, 1'b0);
        check("bcd_1000", bcd, 16'h1000);
        check("ovf_1000", ovf, 0);

        // Zeros below a nonzero digit stay visible
        wait_an(4'b1101, "an_d1");
        check("seg_d1_1000", seg, 7'h3F);
        wait_an(4'b1011, "an_d2");
        check("seg_d2_1000", seg, 7'h3F);
        wait_an(4'b0111, "an_d3");
        check("seg_d3_1000", seg, 7'h06);
        wait_an(4'b1110, "an_d0");
        check("seg_d0_1000", seg, 7'h3F);

        // Wrap at all-9s
        tics(8999, 1'b0);
        check("bcd_9999", bcd, 16'h9999);
        check("ovf_9999", ovf, 0);
        tics(1, 1'b0);
        check("bcd_wrap", bcd, 16'h0000);
        check("ovf_wrap", ovf, 1);
        tics(3, 1'b0);
        check("bcd_0003", bcd, 16'h0003);
        check("ovf_sticky", ovf, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("bcd_clr", bcd, 0);
        check("ovf_clr", ovf, 0);

        // Full segment map on the units digit
        for (int d = 0; d < 10; d++) begin
            wait_an(4'b1110, $sformatf("an_map%0d", d));
            check($sformatf("seg_map%0d", d), seg, seg_tab[d]);
            tics(1, 1'b0);
        end
        check("bcd_0010", bcd, 16'h0010);

        // Saturating instance
        tics(9999, 1'b1);
        check("sat_bcd_9999", bcd_s, 16'h9999);
        check("sat_ovf_9999", ovf_s, 0);
        tics(1, 1'b1);
        check("sat_bcd_hold1", bcd_s, 16'h9999);
        check("sat_ovf_set", ovf_s, 1);
        tics(1, 1'b1);
        check("sat_bcd_hold2", bcd_s, 16'h9999);
        check("sat_ovf_hold", ovf_s, 1);

        // clr beats tic in the same cycle
        clr = 1'b1;
        step();
        clr = 1'b0;
        tics(42, 1'b0);
        check("bcd_0042", bcd, 16'h0042);
        clr = 1'b1;
        tic = 1'b1;
        step();
        clr = 1'b0;
        tic = 1'b0;
        check("bcd_clr_tic", bcd, 0);

        // Reset in the middle of a scan
        tics(5, 1'b0);
        wait_an(4'b1011, "an_pre_rst");
        check("bcd_pre_rst", bcd, 16'h0005);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_an", an, 4'b1110);
        check("midrst_bcd", bcd, 0);
        check("midrst_seg", seg, 7'h3F);
        check("midrst_ovf_sat", ovf_s, 0);
        check("midrst_bcd_sat", bcd_s, 0);

        // Scan timing with blanking: an rotates every 4 cycles, only the units digit lit
        tics(7, 1'b0);
        step();
        check("bcd_0007", bcd, 16'h0007);
        for (int i = 0; i < 32; i++) begin
            step();
            idx = ((n_edges - 1) / 4) % 4;
            check($sformatf("scan_an_%0d", n_edges), {28'd0, an}, {28'd0, ~(4'b0001 << idx)});
            check($sformatf("scan_seg_%0d", n_edges), {25'd0, seg}, (idx == 0) ? 32'h07 : 32'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
